// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: issues word fetches, queues returned words with their PC, handles redirects.
// Latency: a response is visible at the queue head the cycle after it arrives (no bypass).
// Backpressure: requests are credit-limited by queue space plus in-flight count; out_ready stalls the head.
module inst_fetch_buffer #(
    parameter int              PC_W      = 64,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [PC_W-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [31:0]     resp_inst,
    input  logic            resp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Queue storage; contents are only meaningful between rd_ptr and wr_ptr, so no reset.
    logic [PC_W-1:0] q_pc   [DEPTH];
    logic [31:0]     q_inst [DEPTH];
    logic            q_err  [DEPTH];

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  resp_pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] outstanding_nxt;
    logic [OUT_W-1:0] drop;
    logic [SUM_W-1:0] credit_used;
    logic [PC_W-1:0]  redirect_aligned;

    logic req_fire;
    logic resp_take;
    logic push;
    logic pop;

    assign redirect_aligned = redirect_pc & ~PC_W'(3);

    // Every queued word or in-flight request holds one queue slot, so a response always has room.
    assign credit_used = SUM_W'(count) + SUM_W'(outstanding);
    assign req_valid   = rst && !redirect_valid
                         && (credit_used < SUM_W'(DEPTH))
                         && (outstanding < OUT_W'(MAX_OUTST));
    assign req_addr    = fetch_pc;
    assign req_fire    = req_valid && req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored outright.
    assign resp_take = resp_valid && (outstanding != '0);
    // Words still owed to a superseded fetch stream are swallowed while drop is non-zero.
    assign push      = resp_take && (drop == '0) && !redirect_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;

    assign out_valid = (count != '0);
    assign out_pc    = q_pc[rd_ptr];
    assign out_inst  = out_valid ? q_inst[rd_ptr] : NOP_INST;
    assign out_err   = out_valid && q_err[rd_ptr];

    // In-flight request count: +1 per accepted request, -1 per accepted response.
    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire && !resp_take) begin
            outstanding_nxt = outstanding + OUT_W'(1);
        end else if (!req_fire && resp_take) begin
            outstanding_nxt = outstanding - OUT_W'(1);
        end
    end

    // Queue occupancy: simultaneous push and pop leaves it unchanged, even when full.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Control state; a redirect flushes the queue and marks every still-owed response for dropping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                drop     <= outstanding_nxt;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_W'(4);
                end
                if (resp_take && (drop != '0)) begin
                    drop <= drop - OUT_W'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_W'(4);
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count_nxt;
            end
        end
    end

    // Write the accepted word with the PC of the request it answers at the queue tail.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= resp_pc;
            q_inst[wr_ptr] <= resp_inst;
            q_err[wr_ptr]  <= resp_err;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized bench for inst_fetch_buffer with an in-order memory model and an epoch-based
// reference of the expected instruction stream.
module tb_inst_fetch_buffer;

    localparam int          PC_W      = 64;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [63:0] RESET_PC  = 64'h8000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            req_valid;
    logic            req_ready = 1'b0;
    logic [PC_W-1:0] req_addr;
    logic            resp_valid = 1'b0;
    logic [31:0]     resp_inst = '0;
    logic            resp_err = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            out_err;

    inst_fetch_buffer #(
        .PC_W(PC_W), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_inst(resp_inst), .resp_err(resp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory contents and fault map as pure functions of the word address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic err_fn(input logic [63:0] a);
        return a[5:2] == 4'd2;
    endfunction

    function automatic logic [63:0] pick_rpc();
        logic [63:0] r;
        if ($urandom_range(0, 7) == 0) r = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        else                           r = RESET_PC + 64'($urandom_range(0, 255));
        return r;
    endfunction

    // Reference state: requests the memory holds (tagged with the fetch epoch that issued them)
    // and PCs that should currently be queued in the buffer, oldest first.
    typedef struct {
        logic [63:0] addr;
        logic [63:0] pc;
        int          epoch;
    } fl_t;

    fl_t         inflight[$];
    logic [63:0] model_q[$];
    logic [63:0] fetch_exp = RESET_PC;
    int          epoch = 0;
    int          reqs_seen = 0;
    int          pops_seen = 0;
    logic [63:0] first_pop = '0;
    logic [63:0] rpc_fixed = '0;
    int          bogus_pct = 0;

    // Each iteration starts at a falling edge and ends at the next falling edge.
    task automatic do_cycles(input int n, input int p_rdy, input int p_resp, input int p_out, input int p_redir);
        for (int i = 0; i < n; i++) begin
            logic        s_rv, s_rr, s_respv, s_red, s_ov, s_ordy, exp_rv;
            logic [63:0] s_rpc, s_raddr, s_opc, head;
            fl_t         ent;

            req_ready      = ($urandom_range(0, 99) < p_rdy);
            out_ready      = ($urandom_range(0, 99) < p_out);
            redirect_valid = ($urandom_range(0, 99) < p_redir);
            redirect_pc    = (rpc_fixed != 0) ? rpc_fixed : pick_rpc();
            resp_valid     = 1'b0;
            resp_inst      = $urandom;
            resp_err       = 1'($urandom_range(0, 1));
            if (inflight.size() != 0) begin
                if ($urandom_range(0, 99) < p_resp) begin
                    resp_valid = 1'b1;
                    resp_inst  = mem_word(inflight[0].addr);
                    resp_err   = err_fn(inflight[0].addr);
                end
            end else if ($urandom_range(0, 99) < bogus_pct) begin
                resp_valid = 1'b1;
            end
            #1;

            exp_rv = (model_q.size() + inflight.size() < DEPTH) && (inflight.size() < MAX_OUTST)
                     && !redirect_valid;
            check_val("req_valid", req_valid, exp_rv);
            check_val("req_addr", req_addr, fetch_exp);
            check_val("out_valid", out_valid, model_q.size() != 0);
            if (model_q.size() != 0) begin
                head = model_q[0];
                check_val("out_pc", out_pc, head);
                check_val("out_inst", out_inst, mem_word(head));
                check_val("out_err", out_err, err_fn(head));
            end else begin
                check_val("idle_inst", out_inst, NOP);
                check_val("idle_err", out_err, 1'b0);
            end

            s_rv = req_valid;  s_rr = req_ready;  s_raddr = req_addr;
            s_respv = resp_valid;  s_red = redirect_valid;  s_rpc = redirect_pc;
            s_ov = out_valid;  s_ordy = out_ready;  s_opc = out_pc;

            @(posedge clk);
            if (s_ov && s_ordy && !s_red) begin
                if (pops_seen == 0) first_pop = s_opc;
                pops_seen++;
            end
            if (s_ordy && !s_red && model_q.size() != 0) void'(model_q.pop_front());
            if (s_respv && inflight.size() != 0) begin
                ent = inflight.pop_front();
                if (!s_red && ent.epoch == epoch) model_q.push_back(ent.pc);
            end
            if (s_rv && s_rr) begin
                reqs_seen++;
                inflight.push_back('{addr: s_raddr, pc: fetch_exp, epoch: epoch});
                fetch_exp = fetch_exp + 64'd4;
            end
            if (s_red) begin
                model_q.delete();
                epoch++;
                fetch_exp = s_rpc & ~64'h3;
            end
            @(negedge clk);
        end
    endtask

    // Entered at a falling edge; asserts reset between edges and checks its immediate effect.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_req_valid", req_valid, 1'b0);
        check_val("rst_out_inst", out_inst, NOP);
        check_val("rst_out_err", out_err, 1'b0);
        check_val("rst_req_addr", req_addr, RESET_PC);
        inflight.delete();
        model_q.delete();
        fetch_exp = RESET_PC;
        epoch++;
        redirect_valid = 1'b0;
        resp_valid = 1'b0;
        req_ready = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();

        // Streaming with a single-cycle memory: one word per cycle from the third cycle.
        pops_seen = 0;
        do_cycles(10, 100, 100, 100, 0);
        check_val("stream_pops", pops_seen, 8);
        check_val("stream_first_pc", first_pop, RESET_PC);

        // Decode stalled: queue fills to DEPTH and fetching stops, then drains in order.
        do_reset();
        reqs_seen = 0;
        do_cycles(12, 100, 100, 0, 0);
        check_val("stall_reqs", reqs_seen, DEPTH);
        check_val("stall_req_valid", req_valid, 1'b0);
        check_val("stall_out_valid", out_valid, 1'b1);
        do_cycles(12, 100, 100, 100, 0);

        // Reset with a full queue, then restart from RESET_PC.
        do_cycles(12, 100, 100, 0, 0);
        do_reset();
        pops_seen = 0;
        do_cycles(8, 100, 100, 100, 0);
        check_val("restart_first_pc", first_pop, RESET_PC);

        // Redirect with two requests in flight: both old words dropped.
        do_reset();
        do_cycles(2, 100, 0, 100, 0);
        rpc_fixed = 64'h8000_0103;
        do_cycles(1, 100, 0, 100, 100);
        check_val("redir_req_addr", req_addr, 64'h8000_0100);
        pops_seen = 0;
        do_cycles(12, 100, 100, 100, 0);
        check_val("redir_first_out", first_pop, 64'h8000_0100);

        // Redirect coinciding with a response and a pop.
        rpc_fixed = 64'h8000_0200;
        do_cycles(1, 100, 100, 100, 100);
        rpc_fixed = '0;
        check_val("redir_pop_empty", out_valid, 1'b0);
        pops_seen = 0;
        do_cycles(10, 100, 100, 100, 0);
        check_val("redir2_first_out", first_pop, 64'h8000_0200);

        // Random traffic, including stray responses with nothing outstanding.
        bogus_pct = 3;
        for (int k = 0; k < 6; k++) begin
            do_cycles(400, $urandom_range(20, 100), $urandom_range(10, 100),
                      $urandom_range(10, 100), $urandom_range(0, 8));
            if (k == 2) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Parameters
REQ-001 SHALL provide parameter PC_W, default 64, fetch-address and PC width.
REQ-002 SHALL provide parameter DEPTH, default 4, instruction queue entries; power of two, at least 2.
REQ-003 SHALL provide parameter MAX_OUTST, default 2, maximum memory requests in flight.
REQ-004 SHALL provide parameter RESET_PC, default 64'h8000_0000, first fetch address.

Interface
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low: rst=0 resets.
REQ-007 redirect_valid  input  1  pipeline redirect (taken branch/jump).
REQ-008 redirect_pc  input  PC_W  new fetch address; bit 1:0 ignored, treated as 0.
REQ-009 req_valid  output  1  fetch request to instruction memory.
REQ-010 req_ready  input  1  memory accepts request.
REQ-011 req_addr  output  PC_W  word-aligned fetch address.
REQ-012 resp_valid  input  1  memory returns one word; responses in request order.
REQ-013 resp_inst  input  32  returned instruction.
REQ-014 resp_err  input  1  access fault for that word.
REQ-015 out_valid  output  1  queue head valid toward IF/ID register.
REQ-016 out_ready  input  1  decode stage consumes head.
REQ-017 out_pc  output  PC_W  PC of head instruction.
REQ-018 out_inst  output  32  head instruction; 32'h0000_0013 (NOP) when out_valid=0.
REQ-019 out_err  output  1  head carries access fault.

Function
REQ-020 fetch_pc register SHALL hold next request address; +4 on each request handshake (req_valid & req_ready), wrapping modulo 2^PC_W.
REQ-021 req_valid SHALL be 1 iff count + outstanding < DEPTH, outstanding < MAX_OUTST, redirect_valid=0, rst=1.
REQ-022 req_addr SHALL equal fetch_pc; stable while req_valid=1 and req_ready=0.
REQ-023 outstanding SHALL increment on request handshake, decrement on resp_valid, unchanged when both occur in one cycle.
REQ-024 Accepted response with drop=0 SHALL be written to the queue tail as {pc, inst, err}, pc = address of the matching request (tracked by a resp_pc register advanced +4 per accepted response).
REQ-025 Push and pop in the same cycle SHALL be legal at any count, including full; count unchanged.
REQ-026 out_valid SHALL equal (count != 0); a pop occurs on out_valid & out_ready; head visible the cycle after push (1-cycle response-to-output latency, no bypass).
REQ-027 Queue pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH; the credit rule of REQ-021 guarantees no push while full without a pop.
REQ-028 On redirect_valid=1 at a rising edge: queue emptied (count=0, pointers equal), fetch_pc and resp_pc := redirect_pc & ~3, drop := outstanding after this cycle's update; any pop or push that cycle is cancelled.
REQ-029 While drop != 0, each resp_valid SHALL decrement drop and the word SHALL be discarded (not queued).
REQ-030 Redirect during non-zero drop SHALL recompute drop per REQ-028 (cumulative in-flight count), never lose or double-count a response.
REQ-031 First request after redirect SHALL assert req_valid the cycle after redirect_valid, address redirect_pc & ~3.
REQ-032 resp_valid with outstanding=0 is a protocol violation; block SHALL ignore it and hold state.

Reset
REQ-033 rst=0 SHALL immediately (no clock) force: fetch_pc=resp_pc=RESET_PC, count=0, outstanding=0, drop=0, req_valid=0, out_valid=0, out_err=0, out_inst=NOP.
REQ-034 Reset mid-operation SHALL abandon in-flight requests; the memory model is reset alongside, so no late responses.
REQ-035 First request SHALL issue on the first rising edge after rst deasserts, addr=RESET_PC.

Verification
REQ-036 Reset release, req_ready=1, 1-cycle memory, out_ready=1 -> out_pc 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles after fill.
REQ-037 out_ready=0 held -> exactly DEPTH=4 words queued, req_valid drops to 0, outstanding=0; release -> pc order intact, no gaps/duplicates.
REQ-038 Two requests in flight, redirect_valid with redirect_pc=0x8000_0103 -> both old responses discarded, next req_addr 0x8000_0100, next out_pc 0x8000_0100.
REQ-039 Redirect in same cycle as resp_valid and out_ready pop -> response dropped, queue empty next cycle, drop=outstanding-1 accounting correct.
REQ-040 resp_err=1 on word at 0x8000_0008 -> out_err=1 only with out_pc 0x8000_0008.
REQ-041 rst asserted mid-stream with queue full -> out_valid=0 and req_valid=0 without a clock edge; restart fetches RESET_PC.
